fetch_redirect_ctrl: RTL
========================

Name: fetch_redirect_ctrl

Overview:
- Owns the fetch PC register and selects the next PC from three sources: sequential PC+4, the predictor's taken target, and execute-stage misprediction recovery.
- Carries each fetched instruction's prediction (taken bit and predicted target) through the ID and EX pipeline registers.
- In EX, compares the prediction against the resolved branch outcome, then drives the redirect and flush signals.
- Sits directly upstream of the branch history table: consumes PredF/NPC_PredF and produces PCF, PCE, PredE, NPC_PredE for it.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- CNT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- PredF  in  1  predictor says taken for PCF.
- NPC_PredF  in  32  predicted target for PCF.
- stall_f  in  1  hold PCF.
- stall_d  in  1  hold the ID register.
- stall_e  in  1  hold the EX register; suppresses resolution.
- flush_d_ext  in  1  external ID bubble request (e.g. jump resolved in ID).
- jump_target_d  in  32  redirect target accompanying flush_d_ext.
- is_branch_e  in  1  instruction in EX is a conditional branch.
- BranchE  in  1  resolved outcome: taken.
- BrNPC  in  32  resolved taken target.
- PCF  out  32  current fetch PC.
- PCD  out  32  ID-stage PC.
- PCE  out  32  EX-stage PC.
- PredE  out  1  prediction carried to EX.
- NPC_PredE  out  32  predicted target carried to EX.
- valid_e  out  1  the EX register holds a real instruction.
- mispredict_e  out  1  redirect from EX this cycle (combinational).
- flush_d  out  1  kill ID this cycle.
- flush_e  out  1  kill EX this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - PCF=RESET_PC.
  - PCD=PCE=0, NPC_PredE=0.
  - valid_d, valid_e, PredD, PredE all 0.
  - All outputs are low except PCF.
- Resolution (combinational; active only when valid_e=1 and stall_e=0; otherwise mispredict_e=0):
  - is_branch_e=1, BranchE=1: mispredict if PredE=0 or NPC_PredE!=BrNPC; recovery target BrNPC.
  - is_branch_e=1, BranchE=0: mispredict if PredE=1; recovery target PCE+4.
  - is_branch_e=0: mispredict if PredE=1 (stale predictor entry); recovery target PCE+4.
- Next-PC priority, highest first:
  1. mispredict_e → recovery target.
  2. flush_d_ext → jump_target_d.
  3. stall_f → hold.
  4. PredF → NPC_PredF.
  5. Otherwise PCF+4.
- Address arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Redirects override stall_f: a redirect always loads PCF, even when stall_f=1.
- Flush outputs:
  - flush_d = mispredict_e | flush_d_ext.
  - flush_e = mispredict_e.
- ID register (captures PCF, PredF, NPC_PredF, valid=1):
  - If flush_d: valid_d←0 and PredD←0. This has priority over stall_d.
  - Else if stall_d: hold.
  - Else: capture.
- EX register (captures the ID contents):
  - If flush_e: valid_e←0 and PredE←0. This has priority over stall_e.
  - Else if stall_e: hold.
  - Else if stall_d (with stall_e=0): load a bubble, valid_e←0 and PredE←0.
  - Else: capture.
- Latency:
  - Prediction affects PCF on the next edge.
  - Misprediction penalty is exactly 2 bubbles; PCF equals the recovery target one edge after mispredict_e.
- Simultaneous mispredict_e and flush_d_ext: mispredict wins; jump_target_d is ignored, since the jump was on the wrong path.
- Reset asserted mid-operation: all state clears immediately; fetch restarts at RESET_PC on the first edge after release, with PCF+4 following.

Optional Feature:
- Macro BP_STATS_EN.
- When defined, adds output ports br_cnt and mis_cnt, both [CNT_W-1:0]:
  - br_cnt increments on each resolved conditional branch (valid_e & ~stall_e & is_branch_e).
  - mis_cnt increments on each mispredict_e.
  - Both saturate at all-ones, reset to 0, and count updates in the same edge as the event.
- When undefined, neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=32'h100, PredF=0, no stalls → PCF sequence 100, 104, 108; valid_e first 1 two cycles after PCF=100.
- PredF=1, NPC_PredF=32'h200 at PCF=108 → next PCF=200; at EX, is_branch_e=1, BranchE=1, BrNPC=200 → mispredict_e=0, no flush.
- Predicted taken (PredE=1, PCE=108), resolved BranchE=0 → mispredict_e=1, flush_d=flush_e=1, next PCF=10C, valid_e=0 the following cycle.
- PredE=1 with NPC_PredE=200 vs BrNPC=240, taken → redirect to 240; with BP_STATS_EN, mis_cnt 0→1 and br_cnt 0→1.
- stall_f=stall_d=1 while mispredict_e=1 → PCF still loads recovery target; the ID flush beats the stall; stall_e=1 instead → mispredict_e=0, nothing changes.
- PCF=32'hFFFF_FFFC, PredF=0 → PCF=0; mispredict_e and flush_d_ext together → PCF equals recovery target, not jump_target_d.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch PC owner, prediction carry to EX, misprediction redirect/flush (optional BP_STATS_EN counters)
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PredF,
    input  logic [31:0]      NPC_PredF,
    input  logic             stall_f,
    input  logic             stall_d,
    input  logic             stall_e,
    input  logic             flush_d_ext,
    input  logic [31:0]      jump_target_d,
    input  logic             is_branch_e,
    input  logic             BranchE,
    input  logic [31:0]      BrNPC,
    output logic [31:0]      PCF,
    output logic [31:0]      PCD,
    output logic [31:0]      PCE,
    output logic             PredE,
    output logic [31:0]      NPC_PredE,
    output logic             valid_e,
    output logic             mispredict_e,
    output logic             flush_d,
    output logic             flush_e
`ifdef BP_STATS_EN
    ,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic [31:0] pcf_q, pcf_d;
    logic [31:0] pcd_q, pcd_d;
    logic        pred_d_q, pred_d_d;
    logic [31:0] npc_pred_d_q, npc_pred_d_d;
    logic        valid_d_q, valid_d_d;
    logic [31:0] pce_q, pce_d;
    logic        pred_e_q, pred_e_d;
    logic [31:0] npc_pred_e_q, npc_pred_e_d;
    logic        valid_e_q, valid_e_d;

    logic        mis;
    logic [31:0] rec_tgt;

    // Resolve the EX-stage prediction against the actual branch outcome
    always_comb begin
        mis     = 1'b0;
        rec_tgt = pce_q + 32'd4;
        if (valid_e_q && !stall_e) begin
            if (is_branch_e && BranchE) begin
                rec_tgt = BrNPC;
                mis     = !pred_e_q || (npc_pred_e_q != BrNPC);
            end else begin
                // not-taken branch or non-branch with a stale taken prediction
                mis = pred_e_q;
            end
        end
    end

    // Next fetch PC selection and pipeline register next-state
    always_comb begin
        pcf_d        = pcf_q;
        pcd_d        = pcd_q;
        pred_d_d     = pred_d_q;
        npc_pred_d_d = npc_pred_d_q;
        valid_d_d    = valid_d_q;
        pce_d        = pce_q;
        pred_e_d     = pred_e_q;
        npc_pred_e_d = npc_pred_e_q;
        valid_e_d    = valid_e_q;

        if (mis)              pcf_d = rec_tgt;
        else if (flush_d_ext) pcf_d = jump_target_d;
        else if (stall_f)     pcf_d = pcf_q;
        else if (PredF)       pcf_d = NPC_PredF;
        else                  pcf_d = pcf_q + 32'd4;

        if (mis || flush_d_ext) begin
            valid_d_d = 1'b0;
            pred_d_d  = 1'b0;
        end else if (!stall_d) begin
            pcd_d        = pcf_q;
            pred_d_d     = PredF;
            npc_pred_d_d = NPC_PredF;
            valid_d_d    = 1'b1;
        end

        if (mis) begin
            valid_e_d = 1'b0;
            pred_e_d  = 1'b0;
        end else if (stall_e) begin
            valid_e_d = valid_e_q;
        end else if (stall_d) begin
            // ID is held but EX advances: feed a bubble so nothing executes twice
            valid_e_d = 1'b0;
            pred_e_d  = 1'b0;
        end else begin
            pce_d        = pcd_q;
            pred_e_d     = pred_d_q;
            npc_pred_e_d = npc_pred_d_q;
            valid_e_d    = valid_d_q;
        end
    end

    // Pipeline state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf_q        <= RESET_PC;
            pcd_q        <= 32'd0;
            pred_d_q     <= 1'b0;
            npc_pred_d_q <= 32'd0;
            valid_d_q    <= 1'b0;
            pce_q        <= 32'd0;
            pred_e_q     <= 1'b0;
            npc_pred_e_q <= 32'd0;
            valid_e_q    <= 1'b0;
        end else begin
            pcf_q        <= pcf_d;
            pcd_q        <= pcd_d;
            pred_d_q     <= pred_d_d;
            npc_pred_d_q <= npc_pred_d_d;
            valid_d_q    <= valid_d_d;
            pce_q        <= pce_d;
            pred_e_q     <= pred_e_d;
            npc_pred_e_q <= npc_pred_e_d;
            valid_e_q    <= valid_e_d;
        end
    end

    assign PCF          = pcf_q;
    assign PCD          = pcd_q;
    assign PCE          = pce_q;
    assign PredE        = pred_e_q;
    assign NPC_PredE    = npc_pred_e_q;
    assign valid_e      = valid_e_q;
    assign mispredict_e = mis;
    assign flush_d      = mis | flush_d_ext;
    assign flush_e      = mis;

`ifdef BP_STATS_EN
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    // Saturating branch and misprediction counters
    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (valid_e_q && !stall_e && is_branch_e && (br_cnt_q != {CNT_W{1'b1}}))
            br_cnt_d = br_cnt_q + CNT_W'(1);
        if (mis && (mis_cnt_q != {CNT_W{1'b1}}))
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign br_cnt  = br_cnt_q;
    assign mis_cnt = mis_cnt_q;
`endif

endmodule
